// File: rtl/rs422_test_seq_if.sv
// OPB register bus between the test sequencer (master)
// and the RS422 loopback test slave.
interface rs422_test_seq_if;
    logic [31:0] OPB_ADDR;
    logic [31:0] OPB_DI;
    logic [31:0] OPB_DO;
    logic        RS422_WE;
    logic        RS422_RE;

    modport master (
        output OPB_ADDR, OPB_DI, RS422_WE, RS422_RE,
        input  OPB_DO
    );
    modport slave (
        input  OPB_ADDR, OPB_DI, RS422_WE, RS422_RE,
        output OPB_DO
    );
endinterface

// File: rtl/rs422_test_seq.sv
// RS422 loopback test sequencer: programs the test slave, polls for
// transmit completion, settles, then reads back and judges all counters.
module rs422_test_seq #(
    parameter int unsigned POLL_INTERVAL = 16,
    parameter int unsigned TIMEOUT_POLLS = 65535,
    parameter int unsigned SETTLE_CYCLES = 17360
) (
    input  logic             OPB_CLK,
    input  logic             OPB_RST,
    input  logic             GO,
    input  logic [7:0]       PATTERN,
    input  logic [31:0]      BYTE_COUNT,
    rs422_test_seq_if.master bus,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic             TIMEOUT,
    output logic [8:0]       RX_OK,
    output logic [31:0]      TOTAL_ERR
);
    typedef enum logic [2:0] {
        S_IDLE, S_WRITES, S_POLL, S_PWAIT,
        S_STOP, S_SETTLE, S_READ, S_FINISH
    } state_t;

    state_t      r_state, w_state;
    logic [1:0]  r_phase, w_phase;
    logic [4:0]  r_idx, w_idx;
    logic [31:0] r_cnt, w_cnt;
    logic [31:0] r_polls, w_polls;
    logic [7:0]  r_pat, w_pat;
    logic [31:0] r_bc, w_bc;
    logic [8:0]  r_recv_ok, w_recv_ok;
    logic [31:0] r_addr, w_addr;
    logic [31:0] r_di, w_di;
    logic        r_we, w_we;
    logic        r_re, w_re;
    logic        r_busy, w_busy;
    logic        r_done, w_done;
    logic        r_pass, w_pass;
    logic        r_tmo, w_tmo;
    logic [8:0]  r_rx_ok, w_rx_ok;
    logic [31:0] r_terr, w_terr;

    logic [7:0]  w_wr_addr;
    logic [31:0] w_wr_data;
    logic [4:0]  w_item;
    logic [3:0]  w_ch;
    logic [32:0] w_sum;

    // Setup write table: clear, pattern, count, start.
    always_comb begin
        unique case (r_idx[1:0])
            2'd0:    begin w_wr_addr = 8'h02; w_wr_data = 32'd4; end
            2'd1:    begin w_wr_addr = 8'h00; w_wr_data = {24'd0, r_pat}; end
            2'd2:    begin w_wr_addr = 8'h01; w_wr_data = r_bc; end
            default: begin w_wr_addr = 8'h02; w_wr_data = 32'd1; end
        endcase
    end

    assign w_item = r_idx - 5'd1;
    assign w_ch   = 4'(w_item - 5'd9);
    assign w_sum  = {1'b0, r_terr} + {1'b0, bus.OPB_DO};

    always_comb begin
        w_state   = r_state;
        w_phase   = r_phase;
        w_idx     = r_idx;
        w_cnt     = r_cnt;
        w_polls   = r_polls;
        w_pat     = r_pat;
        w_bc      = r_bc;
        w_recv_ok = r_recv_ok;
        w_addr    = r_addr;
        w_di      = r_di;
        w_we      = r_we;
        w_re      = r_re;
        w_busy    = r_busy;
        w_done    = 1'b0;
        w_pass    = r_pass;
        w_tmo     = r_tmo;
        w_rx_ok   = r_rx_ok;
        w_terr    = r_terr;
        unique case (r_state)
            S_IDLE: begin
                if (GO) begin
                    w_pat   = PATTERN;
                    w_bc    = BYTE_COUNT;
                    w_pass  = 1'b0;
                    w_tmo   = 1'b0;
                    w_rx_ok = '0;
                    w_terr  = '0;
                    w_busy  = 1'b1;
                    w_phase = 2'd0;
                    w_idx   = '0;
                    w_state = (BYTE_COUNT == 32'd0) ? S_FINISH : S_WRITES;
                end
            end
            S_WRITES: begin
                if (r_phase == 2'd0) begin
                    w_we    = 1'b1;
                    w_addr  = {24'd0, w_wr_addr};
                    w_di    = w_wr_data;
                    w_phase = 2'd1;
                end else begin
                    w_we    = 1'b0;
                    w_di    = '0;
                    w_phase = 2'd0;
                    if (r_idx == 5'd3) begin
                        w_idx   = '0;
                        w_polls = '0;
                        w_state = S_POLL;
                    end else begin
                        w_idx = r_idx + 5'd1;
                    end
                end
            end
            S_POLL: begin
                if (r_phase == 2'd0) begin
                    w_re    = 1'b1;
                    w_addr  = 32'h03;
                    w_phase = 2'd1;
                end else if (r_phase == 2'd1) begin
                    w_re    = 1'b0;
                    w_phase = 2'd2;
                end else begin
                    w_phase = 2'd0;
                    // Completion seen on the last allowed poll is not a timeout.
                    if (bus.OPB_DO[0]) begin
                        w_state = S_STOP;
                    end else begin
                        w_polls = r_polls + 32'd1;
                        if (r_polls + 32'd1 >= TIMEOUT_POLLS) begin
                            w_tmo   = 1'b1;
                            w_state = S_STOP;
                        end else begin
                            w_cnt   = '0;
                            w_state = S_PWAIT;
                        end
                    end
                end
            end
            S_PWAIT: begin
                if (r_cnt + 32'd1 >= POLL_INTERVAL) w_state = S_POLL;
                else w_cnt = r_cnt + 32'd1;
            end
            S_STOP: begin
                if (r_phase == 2'd0) begin
                    w_we    = 1'b1;
                    w_addr  = 32'h02;
                    w_di    = 32'd2;
                    w_phase = 2'd1;
                end else begin
                    w_we    = 1'b0;
                    w_di    = '0;
                    w_phase = 2'd0;
                    w_cnt   = '0;
                    w_state = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_cnt + 32'd1 >= SETTLE_CYCLES) begin
                    w_idx   = '0;
                    w_phase = 2'd0;
                    w_state = S_READ;
                end else begin
                    w_cnt = r_cnt + 32'd1;
                end
            end
            S_READ: begin
                if (r_phase == 2'd0) begin
                    // Capture the previous read while launching the next one.
                    if (r_idx != 5'd0) begin
                        if (w_item < 5'd9) begin
                            w_recv_ok[w_item[3:0]] = (bus.OPB_DO == r_bc);
                        end else begin
                            w_rx_ok[w_ch] = r_recv_ok[w_ch] &&
                                            (bus.OPB_DO == 32'd0);
                            w_terr = w_sum[32] ? '1 : w_sum[31:0];
                        end
                    end
                    if (r_idx == 5'd18) begin
                        w_state = S_FINISH;
                    end else begin
                        w_re    = 1'b1;
                        w_addr  = {27'd0, r_idx} + 32'd4;
                        w_idx   = r_idx + 5'd1;
                        w_phase = 2'd1;
                    end
                end else begin
                    w_re    = 1'b0;
                    w_phase = 2'd0;
                end
            end
            S_FINISH: begin
                w_pass  = (&r_rx_ok) && !r_tmo;
                w_done  = 1'b1;
                w_busy  = 1'b0;
                w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            r_state   <= S_IDLE;
            r_phase   <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_polls   <= '0;
            r_pat     <= '0;
            r_bc      <= '0;
            r_recv_ok <= '0;
            r_addr    <= '0;
            r_di      <= '0;
            r_we      <= 1'b0;
            r_re      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_tmo     <= 1'b0;
            r_rx_ok   <= '0;
            r_terr    <= '0;
        end else begin
            r_state   <= w_state;
            r_phase   <= w_phase;
            r_idx     <= w_idx;
            r_cnt     <= w_cnt;
            r_polls   <= w_polls;
            r_pat     <= w_pat;
            r_bc      <= w_bc;
            r_recv_ok <= w_recv_ok;
            r_addr    <= w_addr;
            r_di      <= w_di;
            r_we      <= w_we;
            r_re      <= w_re;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_pass    <= w_pass;
            r_tmo     <= w_tmo;
            r_rx_ok   <= w_rx_ok;
            r_terr    <= w_terr;
        end
    end

    assign bus.OPB_ADDR = r_addr;
    assign bus.OPB_DI   = r_di;
    assign bus.RS422_WE = r_we;
    assign bus.RS422_RE = r_re;
    assign BUSY         = r_busy;
    assign DONE         = r_done;
    assign PASS         = r_pass;
    assign TIMEOUT      = r_tmo;
    assign RX_OK        = r_rx_ok;
    assign TOTAL_ERR    = r_terr;
endmodule

// File: tb/tb_rs422_test_seq.sv
// Bench for rs422_test_seq: behavioural RS422 test slave, bus protocol
// monitor and a result model derived from counter and status contents.
module tb_rs422_test_seq;
    localparam int unsigned PI = 3;
    localparam int unsigned TP = 4;
    localparam int unsigned SC = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        go  = 1'b0;
    logic [7:0]  pat = '0;
    logic [31:0] bc  = '0;
    logic        busy, done, pass, tmo;
    logic [8:0]  rx_ok;
    logic [31:0] terr;

    rs422_test_seq_if bus ();

    rs422_test_seq #(
        .POLL_INTERVAL(PI),
        .TIMEOUT_POLLS(TP),
        .SETTLE_CYCLES(SC)
    ) dut (
        .OPB_CLK   (clk),
        .OPB_RST   (rst),
        .GO        (go),
        .PATTERN   (pat),
        .BYTE_COUNT(bc),
        .bus       (bus),
        .BUSY      (busy),
        .DONE      (done),
        .PASS      (pass),
        .TIMEOUT   (tmo),
        .RX_OK     (rx_ok),
        .TOTAL_ERR (terr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] recv_v [9];
    logic [31:0] err_v  [9];
    int          complete_on = 0;
    int          poll_total  = 0;
    int          poll_base   = 0;
    logic [39:0] wr_q [$];
    logic [7:0]  rd_q [$];
    int          viol = 0;
    logic        prev_we = 1'b0;
    logic        prev_re = 1'b0;

    // Slave: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.RS422_WE)
            wr_q.push_back({bus.OPB_ADDR[7:0], bus.OPB_DI});
        if (bus.RS422_RE) begin
            rd_q.push_back(bus.OPB_ADDR[7:0]);
            if (bus.OPB_ADDR[7:0] == 8'h03) begin
                poll_total = poll_total + 1;
                bus.OPB_DO <= (complete_on != 0 &&
                    poll_total - poll_base >= complete_on) ? 32'd1 : 32'd0;
            end else if (bus.OPB_ADDR[7:0] >= 8'h04 &&
                         bus.OPB_ADDR[7:0] <= 8'h0C) begin
                bus.OPB_DO <= recv_v[bus.OPB_ADDR[7:0] - 8'h04];
            end else if (bus.OPB_ADDR[7:0] >= 8'h0D &&
                         bus.OPB_ADDR[7:0] <= 8'h15) begin
                bus.OPB_DO <= err_v[bus.OPB_ADDR[7:0] - 8'h0D];
            end else begin
                bus.OPB_DO <= 32'd0;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.RS422_WE && bus.RS422_RE) viol = viol + 1;
        if (bus.RS422_WE && prev_we) viol = viol + 1;
        if (bus.RS422_RE && prev_re) viol = viol + 1;
        if (!bus.RS422_WE && bus.OPB_DI != 32'd0) viol = viol + 1;
        if (bus.OPB_ADDR[31:8] != 24'd0) viol = viol + 1;
        prev_we = bus.RS422_WE;
        prev_re = bus.RS422_RE;
    end

    task automatic set_clean(input logic [31:0] b);
        for (int k = 0; k < 9; k++) begin
            recv_v[k] = b;
            err_v[k]  = 32'd0;
        end
    endtask

    task automatic run_case(input logic [7:0] p, input logic [31:0] b,
                            input int comp, input string name);
        int          wb, rb, vb, n, polls_exp, nw, nr;
        bit          exp_tmo, exp_pass, ok;
        logic [8:0]  exp_ok;
        logic [63:0] sum;
        logic [31:0] exp_terr;
        logic [39:0] ew [5];
        logic [7:0]  ea;

        exp_tmo = (comp == 0) || (comp > int'(TP));
        polls_exp = exp_tmo ? int'(TP) : comp;
        exp_ok = '0;
        sum = '0;
        for (int k = 0; k < 9; k++) begin
            exp_ok[k] = (recv_v[k] == b) && (err_v[k] == 32'd0);
            sum = sum + {32'd0, err_v[k]};
        end
        exp_terr = (sum > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : sum[31:0];
        ew[0] = {8'h02, 32'd4};
        ew[1] = {8'h00, 24'd0, p};
        ew[2] = {8'h01, b};
        ew[3] = {8'h02, 32'd1};
        ew[4] = {8'h02, 32'd2};
        nw = 5;
        nr = polls_exp + 18;
        if (b == 32'd0) begin
            exp_ok = '0; exp_terr = '0; exp_tmo = 1'b0;
            nw = 0; nr = 0; polls_exp = 0;
        end
        exp_pass = (exp_ok == 9'h1FF) && !exp_tmo;

        wb = wr_q.size(); rb = rd_q.size(); vb = viol;
        complete_on = comp;
        poll_base = poll_total;
        @(negedge clk);
        pat = p; bc = b; go = 1'b1;
        @(negedge clk);
        go = 1'b0; pat = 8'($urandom); bc = $urandom;
        checks++;
        if (busy !== 1'b1 || bus.RS422_WE !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_rise: busy=%b we=%b, want busy=1 we=0",
                     name, busy, bus.RS422_WE);
        end
        if (b != 32'd0) begin
            @(negedge clk);
            checks++;
            if (bus.RS422_WE !== 1'b1 || bus.OPB_ADDR !== 32'h02 ||
                bus.OPB_DI !== 32'd4) begin
                errors++;
                $display("FAIL %s first_we: we=%b addr=%h di=%h, want 1/02/4",
                         name, bus.RS422_WE, bus.OPB_ADDR, bus.OPB_DI);
            end
        end
        n = 0;
        while (done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s done_wait: no DONE after %0d cycles, want DONE", name, n);
        end
        if (b == 32'd0) begin
            checks++;
            if (n > 1) begin
                errors++;
                $display("FAIL %s zero_latency: DONE %0d cycles after GO, want <=2",
                         name, n + 1);
            end
        end
        checks++;
        if (pass !== exp_pass || tmo !== exp_tmo || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s flags: pass=%b tmo=%b busy=%b, want %b %b 0",
                     name, pass, tmo, busy, exp_pass, exp_tmo);
        end
        checks++;
        if (rx_ok !== exp_ok) begin
            errors++;
            $display("FAIL %s rx_ok: got %h want %h", name, rx_ok, exp_ok);
        end
        checks++;
        if (terr !== exp_terr) begin
            errors++;
            $display("FAIL %s total_err: got %h want %h", name, terr, exp_terr);
        end
        ok = (wr_q.size() - wb == nw);
        for (int i = 0; i < nw && ok; i++)
            if (wr_q[wb + i] !== ew[i]) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s write_seq: got %0d writes, want %0d in order",
                     name, wr_q.size() - wb, nw);
        end
        ok = (rd_q.size() - rb == nr);
        for (int i = 0; i < nr && ok; i++) begin
            ea = (i < polls_exp) ? 8'h03 : 8'(i - polls_exp + 4);
            if (rd_q[rb + i] !== ea) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s read_seq: got %0d reads, want %0d (%0d polls)",
                     name, rd_q.size() - rb, nr, polls_exp);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || viol != vb) begin
            errors++;
            $display("FAIL %s pulse_proto: done=%b violations=%0d, want 0 and 0",
                     name, done, viol - vb);
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bus.OPB_ADDR, bus.OPB_DI, bus.RS422_WE, bus.RS422_RE, busy,
             done, pass, tmo, rx_ok, terr} !== '0) begin
            errors++;
            $display("FAIL reset_values: addr=%h di=%h we=%b re=%b busy=%b done=%b pass=%b tmo=%b rx_ok=%h terr=%h, want all 0",
                     bus.OPB_ADDR, bus.OPB_DI, bus.RS422_WE, bus.RS422_RE,
                     busy, done, pass, tmo, rx_ok, terr);
        end
        rst = 1'b0;
    endtask

    task automatic test_ideal_loopback();
        set_clean(32'd10);
        run_case(8'hA5, 32'd10, 2, "ideal");
    endtask

    task automatic test_channel_error();
        set_clean(32'd10);
        err_v[3] = 32'd3;
        run_case(8'h3C, 32'd10, 1, "rx4_err");
    endtask

    task automatic test_timeout();
        set_clean(32'd7);
        run_case(8'h55, 32'd7, 0, "timeout");
    endtask

    task automatic test_zero_count();
        set_clean(32'd0);
        run_case(8'hFF, 32'd0, 1, "zero_count");
    endtask

    task automatic test_saturation();
        set_clean(32'd5);
        for (int k = 0; k < 9; k++) err_v[k] = 32'hFFFF_FFF0;
        run_case(8'h01, 32'd5, 3, "saturate");
    endtask

    task automatic test_random();
        logic [31:0] b;
        for (int it = 0; it < 8; it++) begin
            b = $urandom_range(1, 40);
            set_clean(b);
            if (it % 2 == 1) begin
                for (int k = 0; k < 9; k++) begin
                    if ($urandom_range(0, 3) == 0)
                        recv_v[k] = b + 32'($urandom_range(1, 3));
                    if ($urandom_range(0, 3) == 0)
                        err_v[k] = 32'($urandom_range(1, 100));
                end
            end
            run_case(8'($urandom), b, $urandom_range(0, TP + 1), "random");
        end
    endtask

    task automatic test_go_busy_reset();
        int wb, rb, n;
        bit ok;
        set_clean(32'd9);
        complete_on = 0;
        poll_base = poll_total;
        wb = wr_q.size(); rb = rd_q.size();
        @(negedge clk);
        pat = 8'h5A; bc = 32'd9; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        @(negedge clk);
        @(negedge clk);
        pat = 8'h11; bc = 32'd3; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        n = 0;
        while (rd_q.size() == rb && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rd_q.size() == rb) begin
            errors++;
            $display("FAIL busy_go poll_start: no status read after %0d cycles", n);
        end
        ok = (wr_q.size() - wb == 4) && (wr_q[wb] === {8'h02, 32'd4}) &&
             (wr_q[wb + 1] === {8'h00, 32'h5A}) &&
             (wr_q[wb + 2] === {8'h01, 32'd9}) &&
             (wr_q[wb + 3] === {8'h02, 32'd1});
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL busy_go writes: got %0d writes, want the 4 setup writes of the first GO",
                     wr_q.size() - wb);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.OPB_ADDR, bus.OPB_DI, bus.RS422_WE, bus.RS422_RE, busy,
             done, pass, tmo, rx_ok, terr} !== '0) begin
            errors++;
            $display("FAIL midrun_reset: busy=%b we=%b re=%b addr=%h, want all 0",
                     busy, bus.RS422_WE, bus.RS422_RE, bus.OPB_ADDR);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wb = wr_q.size(); rb = rd_q.size();
        repeat (12) @(negedge clk);
        checks++;
        if (wr_q.size() != wb || rd_q.size() != rb || busy !== 1'b0 ||
            done !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: writes=%0d reads=%0d busy=%b done=%b, want 0 0 0 0",
                     wr_q.size() - wb, rd_q.size() - rb, busy, done);
        end
        set_clean(32'd4);
        run_case(8'h99, 32'd4, 1, "after_reset");
    endtask

    initial begin
        test_reset();
        test_ideal_loopback();
        test_channel_error();
        test_timeout();
        test_zero_count();
        test_saturation();
        test_random();
        test_go_busy_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
